// File: rtl/bit_serial_alu_ctrl_if.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_ctrl_if
//   Request/response bundle for the bit-serial add/subtract unit.
//
//   Parameter
//     WIDTH  : operand/result width in bits (must match the attached unit)
//
//   Signals
//     start  : request a new operation (driven by the master)
//     op     : 0 = add, 1 = subtract (a - b)
//     a, b   : operands, captured when the request is accepted
//     busy   : unit is running the serial operation
//     done   : one-cycle pulse, result/cout/ovf valid from this cycle on
//     result : WIDTH-bit sum/difference, held until the next accepted start
//     cout   : carry out of the MSB, held with result
//     ovf    : signed overflow, held with result
//
//   Handshake: start acts as a request and "not busy and not done" as the
//   ready. A request is accepted on a rising clock edge where start=1 while
//   the unit is idle; a, b and op are sampled on that same edge. start held
//   high while the unit is busy or in its done cycle is ignored, and is
//   accepted again on the first idle edge. Each accepted request produces
//   exactly one done pulse unless reset intervenes.
// ---------------------------------------------------------------------------
interface bit_serial_alu_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;

  modport master (
    output start, op, a, b,
    input  busy, done, result, cout, ovf
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, cout, ovf
  );
endinterface

// File: rtl/bit_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// bit_serial_alu_ctrl
//   Bit-serial adder/subtractor. One 1-bit full adder is time-shared over all
//   bit positions, LSB first, one bit per clock while in RUN.
//
//   Parameter
//     WIDTH      : operand/result width, 2..64
//
//   Build option
//     SERIAL_ALU_SUB_EN : when defined, op=1 selects a - b (B inverted,
//                         carry-in 1). When undefined every operation is an
//                         addition; op is still a port but is not used.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : asynchronous active-high reset
//     bus        : bit_serial_alu_ctrl_if.slave (start/op/a/b in,
//                  busy/done/result/cout/ovf out)
//     dbg_state  : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Timing: start accepted at edge E0 -> RUN for WIDTH cycles -> done=1 in
//   the cycle after edge E0+WIDTH -> back to IDLE; the next start can be
//   accepted at edge E0+WIDTH+2.
// ---------------------------------------------------------------------------

// Single-bit full adder shared by every bit position.
module bit_serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  bit_serial_alu_ctrl_if.slave   bus,
  output logic [1:0]             dbg_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               fa_a;
  logic               fa_b;
  logic               fa_sum;
  logic               fa_cout;
  logic               carry_init;

`ifdef SERIAL_ALU_SUB_EN
  logic               op_q, op_d;

  // Subtraction is a + ~b + 1: invert the B bit and seed the carry with 1.
  assign fa_b       = b_sh_q[0] ^ op_q;
  assign carry_init = bus.op;
`else
  // Addition only; op is kept on the interface but deliberately unused.
  logic               unused_op;

  assign unused_op  = bus.op;
  assign fa_b       = b_sh_q[0];
  assign carry_init = 1'b0;
`endif

  assign fa_a = a_sh_q[0];

  bit_serial_fa u_fa (
    .a    (fa_a),
    .b    (fa_b),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_ALU_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_ALU_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
`ifdef SERIAL_ALU_SUB_EN
    op_d    = op_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          cnt_d   = '0;
          carry_d = carry_init;
`ifdef SERIAL_ALU_SUB_EN
          op_d    = bus.op;
`endif
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        // Sum bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // On the MSB step carry_q is the carry into the MSB.
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.busy   = (state_q == S_RUN);
  assign bus.done   = (state_q == S_DONE);
  assign bus.result = res_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_alu_ctrl
//   Directed bench for bit_serial_alu_ctrl with WIDTH=8. Expected values are
//   hand-computed constants. Outputs are sampled 1 time unit after the rising
//   edge; inputs are driven on the falling edge or right after a sample.
// ---------------------------------------------------------------------------
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  int n_tests;
  int n_fail;

  bit_serial_alu_ctrl_if #(.WIDTH(W)) bus ();

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Clock and reset
  // ---------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------
  // Driver: issue one operation and wait (bounded) for done.
  //   hold_start keeps start=1 and scrambles a/b while the unit is busy.
  //   Returns with the sample point in the done cycle when got_done=1.
  // ---------------------------------------------------------------------
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic top, input bit hold_start,
                       output int busy_cycles, output bit got_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    bus.op    = top;
    @(posedge clk);
    #1;
    if (!hold_start) bus.start = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        got_done = 1'b1;
      end else begin
        if (hold_start) begin
          bus.a = W'($urandom_range(0, 255));
          bus.b = W'($urandom_range(0, 255));
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard for one operation: expected triple in a queue, popped and
  // compared once the operation reports done.
  // ---------------------------------------------------------------------
  logic [W+1:0] exp_q[$];

  task automatic run_and_score(input string tag, input logic [W-1:0] ta,
                               input logic [W-1:0] tb_v, input logic top,
                               input logic [W-1:0] e_res, input logic e_cout,
                               input logic e_ovf);
    int           bc;
    bit           gd;
    logic [W+1:0] e;
    exp_q.push_back({e_res, e_cout, e_ovf});
    do_op(ta, tb_v, top, 1'b0, bc, gd);
    e = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 64'(bc), 64'(W));
    check({tag, "_done"}, 64'(gd), 64'd1);
    check({tag, "_result"}, 64'(bus.result), 64'(e[W+1:2]));
    check({tag, "_cout"}, 64'(bus.cout), 64'(e[1]));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(e[0]));
    // done is a single-cycle pulse and the result is held in IDLE.
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_hold"}, 64'({bus.result, bus.cout, bus.ovf}), 64'(e));
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : stim
    int bc;
    bit gd;
    int done_seen;

    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_state",  64'(dbg_state),  64'd0);
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_cout",   64'(bus.cout),   64'd0);
    check("rst_ovf",    64'(bus.ovf),    64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic addition, carry wrap, signed overflow.
    run_and_score("add35_1c", 8'h35, 8'h1C, 1'b0, 8'h51, 1'b0, 1'b0);
    run_and_score("addff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_and_score("add7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_and_score("add80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Subtraction only when the option is built in; otherwise op is ignored.
`ifdef SERIAL_ALU_SUB_EN
    run_and_score("sub10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_and_score("sub20_10", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
`else
    run_and_score("sub10_20", 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
    run_and_score("sub20_10", 8'h20, 8'h10, 1'b1, 8'h30, 1'b0, 1'b0);
`endif

    // start held high with a/b scrambled during RUN: the latched operands win.
    do_op(8'h12, 8'h34, 1'b0, 1'b1, bc, gd);
    check("hold_busy_cycles", 64'(bc), 64'(W));
    check("hold_done", 64'(gd), 64'd1);
    check("hold_result", 64'(bus.result), 64'h46);
    // Drive the next operands while still in DONE; they must be sampled only
    // on the first IDLE edge.
    bus.a = 8'h02;
    bus.b = 8'h03;
    @(posedge clk);
    #1;
    check("hold_idle_busy", 64'(bus.busy), 64'd0);
    check("hold_idle_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    check("hold_restart_busy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 20 && done_seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen = 1;
    end
    check("hold2_done", 64'(done_seen), 64'd1);
    check("hold2_result", 64'(bus.result), 64'h05);

    // Reset in the middle of RUN.
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.op    = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("mid_busy_before", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy",   64'(bus.busy),   64'd0);
    check("mid_rst_done",   64'(bus.done),   64'd0);
    check("mid_rst_result", 64'(bus.result), 64'd0);
    check("mid_rst_cout",   64'(bus.cout),   64'd0);
    check("mid_rst_ovf",    64'(bus.ovf),    64'd0);
    check("mid_rst_state",  64'(dbg_state),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_seen++;
    end
    check("mid_no_done", 64'(done_seen), 64'd0);
    run_and_score("post_rst", 8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin : watchdog
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  1  0 = add, 1 = subtract (a - b).
REQ-006 a  input  WIDTH  operand A, captured on accepted start.
REQ-007 b  input  WIDTH  operand B, captured on accepted start.
REQ-008 busy  output  1  high while the serial operation runs.
REQ-009 done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 result  output  WIDTH  sum/difference, held until the next accepted start.
REQ-011 cout  output  1  final carry out of the MSB, held with result.
REQ-012 ovf  output  1  signed overflow, held with result.

Function
REQ-013 The block SHALL instantiate exactly one 1-bit full adder (sum = a^b^cin, cout = majority) and time-share it across all bit positions.
REQ-014 FSM states SHALL be IDLE, RUN and DONE; reset state IDLE.
REQ-015 IDLE: start=1 at a rising edge SHALL latch a, b and op into shift registers, clear the bit counter, load the carry register (0 for add, 1 for subtract) and enter RUN; start=0 keeps IDLE.
REQ-016 RUN: each cycle SHALL feed the LSB of the A register, the LSB of the B register (inverted for subtract) and the carry register into the full adder, shift both operand registers right by one, shift the sum bit into the MSB of the result shift register and store the adder carry.
REQ-017 RUN SHALL last exactly WIDTH cycles (counter 0..WIDTH-1); the edge with counter = WIDTH-1 SHALL enter DONE.
REQ-018 On entry to DONE, result SHALL equal the full WIDTH-bit sum, cout the last adder carry, and ovf the XOR of the carry into the MSB and the carry out of the MSB.
REQ-019 DONE SHALL last one cycle with done=1 and SHALL then return to IDLE unconditionally; start in DONE is ignored.
REQ-020 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; both 0 in IDLE.
REQ-021 Latency: start accepted at edge E0 -> done=1 in the cycle after edge E0+WIDTH; next start accepted no earlier than edge E0+WIDTH+2.
REQ-022 start, op, a and b SHALL be ignored outside IDLE; changes on a/b during RUN SHALL NOT affect the result.
REQ-023 result, cout and ovf SHALL NOT change in IDLE or DONE, and SHALL change during RUN only as the result register shifts.
REQ-024 Carry wrap-around: the carry out of the MSB SHALL be discarded from result (modulo 2^WIDTH) and reported only on cout.

Reset
REQ-025 rst=1 SHALL force, without waiting for a clock edge, state IDLE, counter 0, carry 0, busy 0, done 0, result 0, cout 0, ovf 0.
REQ-026 Asserting rst during RUN or DONE SHALL abort the operation with no done pulse; after release the block SHALL accept a fresh start normally.

Configuration
REQ-027 Macro SERIAL_ALU_SUB_EN: when defined, op=1 SHALL select subtraction per REQ-015/016 (B inverted, carry-in 1).
REQ-028 When SERIAL_ALU_SUB_EN is undefined, op SHALL be ignored, every operation SHALL be an addition with carry-in 0, and the inverter and op register SHALL NOT be synthesized; the port op SHALL remain present.

Verification (WIDTH=8)
REQ-029 Add: a=0x35, b=0x1C, op=0, start one cycle -> busy for 8 cycles, done one cycle later, result=0x51, cout=0, ovf=0.
REQ-030 Carry/overflow: a=0xFF, b=0x01 -> result=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1.
REQ-031 Subtract (macro defined): a=0x10, b=0x20, op=1 -> result=0xF0, cout=0, ovf=0; same stimulus without macro -> result=0x30.
REQ-032 Ignored inputs: start held high and a/b toggled during RUN and DONE -> exactly one done per accepted start, result from the latched operands, next operation begins on the first IDLE edge.
REQ-033 Reset mid-run: rst pulsed 4 cycles after start -> busy, done, result, cout, ovf all 0 immediately and no done pulse; subsequent a=0x02, b=0x03 -> result=0x05.
